// File: rtl/nfa_stream_sequencer_if.sv
// rtl/nfa_stream_sequencer_if.sv - byte stream, engine bank and result channel bundle
interface nfa_stream_sequencer_if #(
    parameter int NUM_ENGINES = 8,
    parameter int LEN_W       = 16
);
    logic                   s_valid;
    logic [7:0]             s_data;
    logic                   s_last;
    logic                   s_ready;
    logic                   eng_sod;
    logic                   eng_en;
    logic [7:0]             eng_data;
    logic [NUM_ENGINES-1:0] eng_match;
    logic                   r_valid;
    logic                   r_ready;
    logic [NUM_ENGINES-1:0] r_match;
    logic                   r_any;
    logic [LEN_W-1:0]       r_len;
    logic                   r_sat;

    modport master (
        output s_valid, s_data, s_last, r_ready, eng_match,
        input  s_ready, eng_sod, eng_en, eng_data, r_valid, r_match, r_any, r_len, r_sat
    );

    modport slave (
        input  s_valid, s_data, s_last, r_ready, eng_match,
        output s_ready, eng_sod, eng_en, eng_data, r_valid, r_match, r_any, r_len, r_sat
    );
endinterface

// File: rtl/nfa_stream_sequencer.sv
// rtl/nfa_stream_sequencer.sv - packet sequencer feeding a shared NFA engine bank
module nfa_stream_sequencer #(
    parameter int         NUM_ENGINES  = 8,
    parameter int         DRAIN_CYCLES = 2,
    parameter logic [7:0] FILL_CHAR    = 8'h00,
    parameter int         LEN_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    nfa_stream_sequencer_if.slave    bus
);
    localparam logic [1:0] CLEAR  = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    localparam int                     DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]          DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [LEN_W-1:0]       LEN_MAX    = {LEN_W{1'b1}};
    localparam logic [NUM_ENGINES-1:0] NO_MATCH   = '0;

    logic [1:0]       state;
    logic [DW-1:0]    drain_cnt;
    logic [LEN_W-1:0] len_cnt;
    logic             sat;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            drain_cnt <= '0;
            len_cnt   <= '0;
            sat       <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    state   <= RUN;
                    len_cnt <= '0;
                    sat     <= 1'b0;
                end
                RUN: begin
                    if (bus.s_valid) begin
                        // Length sticks at its maximum; sat records that bytes were dropped from the count.
                        if (len_cnt == LEN_MAX) sat <= 1'b1;
                        else                    len_cnt <= len_cnt + LEN_W'(1);
                        if (bus.s_last) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) state <= REPORT;
                    else                         drain_cnt <= drain_cnt + DW'(1);
                end
                REPORT: begin
                    if (bus.r_ready) state <= CLEAR;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_comb begin
        bus.s_ready  = 1'b0;
        bus.eng_sod  = 1'b0;
        bus.eng_en   = 1'b0;
        bus.eng_data = 8'h00;
        bus.r_valid  = 1'b0;
        bus.r_match  = NO_MATCH;
        bus.r_any    = 1'b0;
        bus.r_len    = '0;
        bus.r_sat    = 1'b0;
        // Held reset looks like CLEAR even before the first edge lands.
        if (!rst) begin
            bus.eng_sod = 1'b1;
        end else begin
            case (state)
                CLEAR: bus.eng_sod = 1'b1;
                RUN: begin
                    bus.s_ready  = 1'b1;
                    bus.eng_en   = bus.s_valid;
                    bus.eng_data = bus.s_valid ? bus.s_data : 8'h00;
                end
                DRAIN: begin
                    bus.eng_en   = 1'b1;
                    bus.eng_data = FILL_CHAR;
                end
                REPORT: begin
                    bus.r_valid = 1'b1;
                    bus.r_match = bus.eng_match;
                    bus.r_any   = |bus.eng_match;
                    bus.r_len   = len_cnt;
                    bus.r_sat   = sat;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nfa_stream_sequencer.sv
// tb/tb_nfa_stream_sequencer.sv - self-checking bench with two counter widths and model engines
module tb_nfa_stream_sequencer;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       r_ready = 1'b0;
    logic [7:0] em;
    int         tests = 0;
    int         fails = 0;

    // Engine k accepts on character ch[k]; FILL_CHAR 8'h00 is outside every alphabet.
    logic [7:0] ch [8] = '{8'h72, 8'h5A, 8'h71, 8'h23, 8'h7E, 8'h21, 8'h40, 8'h25};
    logic [7:0] st1, st2;

    always #5 clk = ~clk;

    nfa_stream_sequencer_if #(.NUM_ENGINES(8), .LEN_W(16)) ia ();
    nfa_stream_sequencer_if #(.NUM_ENGINES(8), .LEN_W(4))  ib ();

    assign ia.s_valid = s_valid;  assign ib.s_valid = s_valid;
    assign ia.s_data  = s_data;   assign ib.s_data  = s_data;
    assign ia.s_last  = s_last;   assign ib.s_last  = s_last;
    assign ia.r_ready = r_ready;  assign ib.r_ready = r_ready;
    assign ia.eng_match = em;     assign ib.eng_match = em;

    nfa_stream_sequencer #(.NUM_ENGINES(8), .DRAIN_CYCLES(2), .FILL_CHAR(8'h00), .LEN_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    nfa_stream_sequencer #(.NUM_ENGINES(8), .DRAIN_CYCLES(2), .FILL_CHAR(8'h00), .LEN_W(4))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    // Two-stage engine pipeline: a hit becomes sticky two enabled cycles after its byte.
    always @(posedge clk) begin
        if (ia.eng_sod) begin
            st1 <= 8'h00; st2 <= 8'h00; em <= 8'h00;
        end else if (ia.eng_en) begin
            for (int k = 0; k < 8; k++) st1[k] <= (ia.eng_data == ch[k]);
            st2 <= st1;
            em  <= em | st2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic rdy, input logic sod, input logic en,
                              input logic [7:0] data, input logic rv);
        check({tag, ".s_ready"}, 32'(ia.s_ready), 32'(rdy));
        check({tag, ".eng_sod"}, 32'(ia.eng_sod), 32'(sod));
        check({tag, ".eng_en"}, 32'(ia.eng_en), 32'(en));
        check({tag, ".eng_data"}, 32'(ia.eng_data), 32'(data));
        check({tag, ".r_valid_a"}, 32'(ia.r_valid), 32'(rv));
        check({tag, ".r_valid_b"}, 32'(ib.r_valid), 32'(rv));
        if (!rv) begin
            check({tag, ".idle_result"}, {ia.r_match, 7'd0, ia.r_any, ia.r_len}, 32'd0);
        end
    endtask

    function automatic logic [7:0] exp_match(input bq_t p);
        logic [7:0] m = 8'h00;
        foreach (p[i]) for (int k = 0; k < 8; k++) if (p[i] == ch[k]) m[k] = 1'b1;
        return m;
    endfunction

    task automatic check_result(input string tag, input bq_t p);
        int n = p.size();
        logic [7:0] m = exp_match(p);
        check({tag, ".r_match"}, 32'(ia.r_match), 32'(m));
        check({tag, ".r_any"}, 32'(ia.r_any), 32'(m != 8'h00));
        check({tag, ".r_len_a"}, 32'(ia.r_len), (n > 65535) ? 32'd65535 : 32'(n));
        check({tag, ".r_sat_a"}, 32'(ia.r_sat), 32'(n > 65535));
        check({tag, ".r_len_b"}, 32'(ib.r_len), (n > 15) ? 32'd15 : 32'(n));
        check({tag, ".r_sat_b"}, 32'(ib.r_sat), 32'(n > 15));
    endtask

    function automatic bq_t to_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t rand_q(input int n);
        bq_t q;
        for (int i = 0; i < n; i++)
            q.push_back(($urandom_range(0, 1) == 0) ? ch[$urandom_range(0, 7)] : 8'($urandom_range(1, 255)));
        return q;
    endfunction

    // Entered at a negedge of a RUN cycle; leaves at the negedge after the CLEAR cycle.
    task automatic send_packet(input string tag, input bq_t p, input bit bubbles, input int hold);
        for (int i = 0; i < p.size(); i++) begin
            if (bubbles && i > 0) begin
                s_valid = 1'b0; s_last = 1'($urandom); s_data = 8'($urandom);
                #1 check_ctrl({tag, ".bubble"}, 1, 0, 0, 8'h00, 0);
                @(negedge clk);
            end
            s_valid = 1'b1; s_data = p[i]; s_last = (i == p.size() - 1);
            #1 check_ctrl({tag, ".byte"}, 1, 0, 1, p[i], 0);
            @(negedge clk);
        end
        s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'($urandom);
        for (int d = 0; d < 2; d++) begin
            #1 check_ctrl({tag, ".drain"}, 0, 0, 1, 8'h00, 0);
            @(negedge clk);
        end
        for (int h = 0; h < hold; h++) begin
            #1 check_ctrl({tag, ".hold"}, 0, 0, 0, 8'h00, 1);
            check_result({tag, ".hold"}, p);
            @(negedge clk);
        end
        r_ready = 1'b1;
        #1 check_ctrl({tag, ".report"}, 0, 0, 0, 8'h00, 1);
        check_result(tag, p);
        @(negedge clk);
        r_ready = 1'($urandom);
        #1 check_ctrl({tag, ".clear"}, 0, 1, 0, 8'h00, 0);
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    initial begin
        bq_t p;
        rst = 1'b0; s_valid = 1'b1; s_data = 8'h41; r_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_ctrl("reset", 0, 1, 0, 8'h00, 0);
        end
        rst = 1'b1;
        #1 check_ctrl("first_clear", 0, 1, 0, 8'h00, 0);
        @(negedge clk);

        send_packet("spy", to_q("Advanced Spy Report for"), 1'b0, 10);
        send_packet("bubble", to_q("abcd"), 1'b1, 0);
        send_packet("one_x", to_q("x"), 1'b0, 1);
        send_packet("sat20", rand_q(20), 1'b0, 0);
        send_packet("len15", rand_q(15), 1'b1, 0);
        send_packet("len16", rand_q(16), 1'b0, 2);

        p = to_q("Z#!qq");
        for (int i = 0; i < p.size(); i++) begin
            s_valid = 1'b1; s_data = p[i]; s_last = 1'b0;
            #1 check_ctrl("abandon.byte", 1, 0, 1, p[i], 0);
            @(negedge clk);
        end
        rst = 1'b0;
        #1 check_ctrl("abandon.rst", 0, 1, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check_ctrl("abandon.clear", 0, 1, 0, 8'h00, 0);
        @(negedge clk);
        send_packet("ab", to_q("ab"), 1'b0, 0);

        for (int r = 0; r < 20; r++)
            send_packet("rand", rand_q($urandom_range(1, 20)), 1'($urandom), $urandom_range(0, 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nfa_stream_sequencer.md
Name: nfa_stream_sequencer

Overview:
Front-end controller for a bank of NUM_ENGINES NFA match engines that share one byte stream. It accepts packets over a valid/ready byte interface and pulses the engines' sod (start-of-data clear) before each packet. It steps the shared engine enable once per accepted byte, then flushes the engine pipeline with fill bytes. Finally it presents the per-engine match vector and packet length to a downstream consumer with a valid/ready handshake.

Parameters:
NUM_ENGINES, 8, number of engines in the bank (width of match vector)
DRAIN_CYCLES, 2, enabled fill cycles after last byte so final char reaches sticky accept state (>=1)
FILL_CHAR, 8'h00, byte driven during drain; must lie outside every engine's character alphabet
LEN_W, 16, width of packet length counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
s_valid  in  1  input byte valid
s_data  in  8  input byte
s_last  in  1  marks final byte of packet
s_ready  out  1  input byte accepted when s_valid & s_ready
eng_sod  out  1  clear to all engines, active-high
eng_en  out  1  shared engine enable
eng_data  out  8  byte to engine character decoders
eng_match  in  NUM_ENGINES  sticky match outputs from engines
r_valid  out  1  result valid
r_ready  in  1  result consumed when r_valid & r_ready
r_match  out  NUM_ENGINES  per-engine match for finished packet
r_any  out  1  OR-reduction of r_match
r_len  out  LEN_W  accepted bytes in packet, saturating
r_sat  out  1  r_len saturated

Behaviour:
- Reset: with rst=0 at a clock edge, the state becomes CLEAR and the length and drain counters are zeroed. Held reset gives eng_sod=1, eng_en=0, eng_data=0, s_ready=0, r_valid=0, r_match=0, r_any=0, r_len=0, r_sat=0.
- A reset asserted mid-packet or mid-report abandons that packet. No result is emitted for it. After release, the block starts from CLEAR.
- FSM states: CLEAR, RUN, DRAIN, REPORT. The state register, drain counter and length counter are registered. All outputs are combinational decodes of state and inputs.
- CLEAR: eng_sod=1, eng_en=0, s_ready=0. Lasts exactly 1 cycle, then goes to RUN and the length counter clears.
- RUN: s_ready=1, eng_sod=0.
  - eng_en = s_valid and eng_data = s_data, so an accepted byte reaches the engines in the same cycle.
  - eng_data=0 when s_valid=0.
  - Each accepted byte increments the length counter. The counter saturates at 2^LEN_W-1 and sets the sat flag; no wrap.
  - An accepted byte with s_last=1 moves the FSM to DRAIN. A 1-byte packet is legal.
- DRAIN: s_ready=0, eng_en=1, eng_data=FILL_CHAR for exactly DRAIN_CYCLES cycles, then REPORT. Input is stalled throughout.
- REPORT:
  - Engines are frozen (eng_en=0, eng_sod=0, s_ready=0).
  - r_valid=1, r_match=eng_match, r_any=|eng_match, r_len and r_sat come from the counters.
  - These values are stable until the handshake. Outside REPORT, r_match, r_any, r_len and r_sat read 0.
  - On r_valid & r_ready the FSM goes to CLEAR. r_valid can only rise again after CLEAR and a new packet.
- Latency: last byte accepted at cycle t gives DRAIN at t+1..t+DRAIN_CYCLES and r_valid from t+DRAIN_CYCLES+1.
- Minimum gap between packets: 1 CLEAR cycle after the result handshake.
- s_valid while s_ready=0 is ignored; the upstream must hold the byte.
- eng_sod and eng_en are never 1 in the same cycle.

Test Plan:
- Reset: hold rst=0 for 3 cycles with s_valid=1 -> s_ready=0, eng_sod=1, r_valid=0. First cycle after release is CLEAR with eng_sod=1, then s_ready=1.
- Single packet, DRAIN_CYCLES=2: send "Advanced Spy Report for" (23 bytes, s_last on 'r'); a model engine 0 sets its sticky output 2 enabled cycles after 'r'.
  - eng_en=1 on 23 byte cycles plus 2 fill cycles with eng_data=8'h00.
  - r_valid rises 3 cycles after the last byte; r_match=8'h01, r_any=1, r_len=23.
- Backpressure: hold r_ready=0 for 10 cycles with s_valid=1 -> r_match and r_len stable, eng_en=0, s_ready=0 throughout. r_ready=1 gives CLEAR (eng_sod=1) next cycle.
- Bubbles and back-to-back packets: s_valid toggling every other cycle, then a 1-byte packet 'x' -> eng_en only on valid cycles. The second result has r_len=1, r_match=0, r_any=0, with one eng_sod pulse between packets.
- Saturation with LEN_W=4: send a 20-byte packet -> r_len=15, r_sat=1.
- Mid-packet reset: rst=0 for 1 cycle after 5 bytes -> no r_valid for that packet. Next packet "ab" reports r_len=2.
